// File: rtl/ads127l01_pkg.sv
// ---------------------------------------------------------------------------
// ads127l01_pkg
// Shared definitions for the ADS127L01 frame-sync transmitter and receiver:
// FSM state encoding, default sample/frame geometry and the pad bit that
// fills frame positions below the sample.
// ---------------------------------------------------------------------------
package ads127l01_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned DW_DEFAULT         = 24;
   localparam int unsigned FRAME_BITS_DEFAULT = 32;

   // Frame bits below the sample are filled with this value.
   localparam logic PAD_BIT = 1'b0;

endpackage

// File: rtl/ads127l01_sck_gen.sv
// ---------------------------------------------------------------------------
// ads127l01_sck_gen
// Divides clk by 2*HALF to form the serial clock. The divider is held at
// zero while not running and restarts (sck low, phase zero) on a frame start,
// so sck rises HALF cycles after every frame start or falling edge.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   run_i      divider enable; low forces sck=0 and the counter to 0
//   restart_i  frame start: sck=0, counter=0 on the next edge
//   sck_o      serial clock (registered)
//   rise_o     high in the cycle before sck rises
//   fall_o     high in the cycle before sck falls
// ---------------------------------------------------------------------------
module ads127l01_sck_gen
   import ads127l01_pkg::*;
#(
   parameter int unsigned HALF = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   input  logic restart_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned     HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HW-1:0]   HMAX = HW'(HALF - 1);

   logic [HW-1:0] hcnt_q;
   logic          sck_q;
   logic          term;

   assign term = (hcnt_q == HMAX);

   // Strobes are deliberately not gated by restart_i: the top derives its
   // frame start from fall_o, and gating here would close a combinational loop.
   assign rise_o = term && !sck_q;
   assign fall_o = term &&  sck_q;
   assign sck_o  = sck_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         sck_q  <= 1'b0;
      end else if (!run_i || restart_i) begin
         hcnt_q <= '0;
         sck_q  <= 1'b0;
      end else if (term) begin
         hcnt_q <= '0;
         sck_q  <= ~sck_q;
      end else begin
         hcnt_q <= hcnt_q + HW'(1);
      end
   end

endmodule

// File: rtl/ads127l01_fs_tx.sv
// ---------------------------------------------------------------------------
// ads127l01_fs_tx
// Frame-sync master serial transmitter emulating the ADS127L01 output port.
// Samples arrive on an AXI-Stream-like input into a one-entry holding
// register; each frame shifts one sample out MSB first, padded to FRAME_BITS
// sck periods, with a one-sck-period fsync pulse at the frame start.
// When no fresh sample is held at a frame start the previous sample is
// resent and underrun pulses for one clk.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   en, start       transmitter enable / START pin (level); both must be high
//                   to run, and the current frame always completes
//   s_axis_tvalid   sample valid
//   s_axis_tready   holding register empty
//   s_axis_tdata    DW-bit two's-complement sample
//   sck             serial clock, period 2*HALF clk
//   fsync           frame-sync pulse, one sck period wide
//   dout            serial data, updated on sck falling edges
//   underrun        one-clk pulse: frame started without a fresh sample
// ---------------------------------------------------------------------------
module ads127l01_fs_tx
   import ads127l01_pkg::*;
#(
   parameter int unsigned DW         = DW_DEFAULT,
   parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
   parameter int unsigned HALF       = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          start,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
   input  logic [DW-1:0] s_axis_tdata,
   output logic          sck,
   output logic          fsync,
   output logic          dout,
   output logic          underrun
);

   localparam int unsigned   BW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   state_e         state_q, state_d;
   logic           first_q;
   logic [BW-1:0]  bit_cnt_q;
   logic           last_bit_q;
   logic [DW-1:0]  shift_q;
   logic [DW-1:0]  sample_q;
   logic [DW-1:0]  hold_q;
   logic           hold_valid_q;
   logic           fsync_q;
   logic           dout_q;
   logic           underrun_q;

   logic           go;
   logic           frame_start;
   logic           handshake;
   logic           sck_rise;
   logic           sck_fall;
   logic [DW-1:0]  frame_sample;
   logic [DW:0]    shift_ext;
   logic [DW-1:0]  shift_nxt;

   assign go            = en && start;
   assign s_axis_tready = !hold_valid_q;
   assign handshake     = s_axis_tvalid && !hold_valid_q;
   assign frame_sample  = hold_valid_q ? hold_q : sample_q;
   assign shift_ext     = {shift_q, PAD_BIT};
   assign shift_nxt     = shift_ext[DW-1:0];

   assign fsync    = fsync_q;
   assign dout     = dout_q;
   assign underrun = underrun_q;

   ads127l01_sck_gen #(
      .HALF (HALF)
   ) u_sck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_i     (state_d == RUN),
      .restart_i (frame_start),
      .sck_o     (sck),
      .rise_o    (sck_rise),
      .fall_o    (sck_fall)
   );

   // The frame boundary is the would-be last falling edge: either the next
   // frame starts there or the FSM drops back to IDLE.
   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) state_d = RUN;
         end
         RUN: begin
            if (first_q) begin
               frame_start = 1'b1;
            end else if (sck_fall && last_bit_q) begin
               if (go) frame_start = 1'b1;
               else    state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= (state_q == IDLE) && go;
      end
   end

   // Holding register: a handshake needs hold_valid_q=0, so it never
   // collides with the clear at a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else if (handshake) begin
         hold_q       <= s_axis_tdata;
         hold_valid_q <= 1'b1;
      end else if (frame_start && hold_valid_q) begin
         hold_valid_q <= 1'b0;
      end
   end

   // last_bit_q is set at the rise of the final sck period so the frame
   // boundary decision only needs a flag at the following fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q  <= '0;
         last_bit_q <= 1'b0;
         shift_q    <= '0;
         sample_q   <= '0;
         fsync_q    <= 1'b0;
         dout_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= frame_start && !hold_valid_q;
         if (state_d == IDLE) begin
            bit_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            fsync_q    <= 1'b0;
            dout_q     <= 1'b0;
         end else if (frame_start) begin
            bit_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            shift_q    <= frame_sample;
            sample_q   <= frame_sample;
            fsync_q    <= 1'b1;
            dout_q     <= frame_sample[DW-1];
         end else begin
            if (sck_fall) begin
               bit_cnt_q <= bit_cnt_q + BW'(1);
               shift_q   <= shift_nxt;
               dout_q    <= shift_nxt[DW-1];
               fsync_q   <= 1'b0;
            end
            if (sck_rise && (bit_cnt_q == BIT_LAST)) begin
               last_bit_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ads127l01_fs_tx.sv
module tb_ads127l01_fs_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        start;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [23:0] s_axis_tdata;
   logic        sck;
   logic        fsync;
   logic        dout;
   logic        underrun;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   ads127l01_fs_tx #(
      .DW         (24),
      .FRAME_BITS (32),
      .HALF       (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .start         (start),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .sck           (sck),
      .fsync         (fsync),
      .dout          (dout),
      .underrun      (underrun)
   );

   // Receiver and timing monitor, sampling on the falling clk edge.
   logic        prev_sck = 1'b0, prev_fs = 1'b0, prev_dout = 1'b0;
   int unsigned cyc = 0, age = 0, since_rise = 100, stab_viol = 0;
   int unsigned fs_len = 0, last_fs_len = 0, last_fs_cyc = 0, last_period = 0;
   int unsigned rise_in_frame = 0, rises_last_frame = 0, rise_total = 0;
   int unsigned fs_rise_total = 0, ur_cnt = 0, pos = 24;
   logic [23:0] rx = '0;
   logic [23:0] rxq[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_sck   = 1'b0;
         prev_fs    = 1'b0;
         prev_dout  = 1'b0;
         age        = 0;
         since_rise = 100;
         fs_len     = 0;
      end else begin
         if (since_rise < 100) since_rise++;
         if (dout !== prev_dout) begin
            age = 0;
            if (since_rise < 4) stab_viol++;
         end else if (age < 1000) begin
            age++;
         end
         if (fsync && !prev_fs) begin
            last_period      = cyc - last_fs_cyc;
            last_fs_cyc      = cyc;
            rises_last_frame = rise_in_frame;
            rise_in_frame    = 0;
            fs_rise_total++;
            fs_len = 0;
         end
         if (fsync) fs_len++;
         if (!fsync && prev_fs) last_fs_len = fs_len;
         if (sck && !prev_sck) begin
            if (age < 4) stab_viol++;
            since_rise = 0;
            rise_total++;
            rise_in_frame++;
            if (fsync) begin
               pos = 0;
               rx  = '0;
            end
            if (pos < 24) begin
               rx = {rx[22:0], dout};
               pos++;
               if (pos == 24) rxq.push_back(rx);
            end
         end
         if (underrun) ur_cnt++;
         prev_sck  = sck;
         prev_fs   = fsync;
         prev_dout = dout;
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [23:0] d, input string tag);
      int unsigned k;
      logic        acc;
      k = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      do begin
         acc = s_axis_tready;
         tick(1);
         k++;
      end while (!acc && k < 700);
      s_axis_tvalid = 1'b0;
      chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_rx(input int unsigned n, input int unsigned budget);
      int unsigned k;
      k = 0;
      while (rxq.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk("rx_count", rxq.size(), n);
   endtask

   task automatic wait_rif(input int unsigned n);
      int unsigned k;
      k = 0;
      while (rise_in_frame != n && k < 600) begin
         tick(1);
         k++;
      end
      chk("rise_in_frame_reach", rise_in_frame, n);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned k;
      int unsigned r0;
      int unsigned f0;

      rst_n = 1'b0; en = 1'b0; start = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0;
      tick(3);
      chk("rst_sck", sck, 0);
      chk("rst_fsync", fsync, 0);
      chk("rst_dout", dout, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_tready", s_axis_tready, 1);
      rst_n = 1'b1;
      tick(20);
      chk("idle_sck", sck, 0);
      chk("idle_rises", rise_total, 0);

      // Loopback of three samples, primed before enabling.
      send(24'h123456, "s0");
      chk("tready_full", s_axis_tready, 0);
      en = 1'b1; start = 1'b1;
      tick(1);
      chk("entry_fsync_lo", fsync, 0);
      tick(1);
      chk("start_fsync", fsync, 1);
      chk("start_sck", sck, 0);
      chk("start_dout", dout, 0);
      chk("start_underrun", underrun, 0);
      chk("start_tready", s_axis_tready, 1);
      send(24'h800000, "s1");
      send(24'h7FFFFF, "s2");
      send(24'hABCDEF, "s3");
      wait_rx(4, 1200);
      chk("rx0", rxq[0], 24'h123456);
      chk("rx1", rxq[1], 24'h800000);
      chk("rx2", rxq[2], 24'h7FFFFF);
      chk("rx3", rxq[3], 24'hABCDEF);
      chk("no_underrun", ur_cnt, 0);
      chk("fsync_len", last_fs_len, 8);
      chk("frame_period", last_period, 256);
      chk("sck_per_frame", rises_last_frame, 32);

      // Starvation: ABCDEF repeats with one underrun per frame.
      rxq.delete();
      ur_cnt = 0;
      wait_rx(3, 1200);
      chk("starve0", rxq[0], 24'hABCDEF);
      chk("starve1", rxq[1], 24'hABCDEF);
      chk("starve2", rxq[2], 24'hABCDEF);
      chk("starve_ur", ur_cnt, 3);

      // en drop mid-frame: frame completes, then outputs idle.
      wait_rif(10);
      en = 1'b0;
      f0 = fs_rise_total;
      tick(400);
      chk("drop_rises", rise_in_frame, 32);
      chk("drop_sck", sck, 0);
      chk("drop_fsync", fsync, 0);
      chk("drop_dout", dout, 0);
      chk("drop_no_frame", fs_rise_total, f0);
      ur_cnt = 0;
      en = 1'b1;
      tick(1);
      chk("reen_fsync_lo", fsync, 0);
      tick(1);
      chk("reen_fsync", fsync, 1);
      chk("reen_underrun", underrun, 1);
      chk("reen_dout", dout, 1);

      // Reset mid-frame.
      send(24'h555555, "s4");
      chk("pre_rst_tready", s_axis_tready, 0);
      wait_rif(15);
      chk("pre_rst_sck", sck, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sck", sck, 0);
      chk("mid_rst_fsync", fsync, 0);
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_underrun", underrun, 0);
      chk("mid_rst_tready", s_axis_tready, 1);
      en = 1'b0;
      r0 = rise_total;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("post_rst_sck", sck, 0);
      chk("post_rst_rises", rise_total, r0);
      rxq.delete();
      ur_cnt = 0;
      en = 1'b1;
      tick(1);
      chk("post_rst_fsync_lo", fsync, 0);
      tick(1);
      chk("post_rst_fsync", fsync, 1);
      chk("post_rst_underrun", underrun, 1);
      wait_rx(1, 400);
      chk("post_rst_zero", rxq[0], 24'h0);
      chk("post_rst_ur", ur_cnt, 1);

      // Handshake coincident with the frame start.
      k = 0;
      while (!fsync && k < 300) begin
         tick(1);
         k++;
      end
      chk("fsync_found", fsync, 1);
      tick(255);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'h3C3C3C;
      tick(1);
      s_axis_tvalid = 1'b0;
      chk("coinc_fsync", fsync, 1);
      chk("coinc_underrun", underrun, 1);
      chk("coinc_tready", s_axis_tready, 0);
      rxq.delete();
      ur_cnt = 0;
      wait_rx(2, 700);
      chk("coinc_rx0", rxq[0], 24'h0);
      chk("coinc_rx1", rxq[1], 24'h3C3C3C);
      chk("coinc_ur", ur_cnt, 1);

      chk("dout_stability", stab_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
